fx3_sample_buffer: RTL and testbench

// - Circular sample buffer feeding the FX3 GPIF write port; sits directly upstream of the FX3 write-control state machine.
// - Accepts one sample word per cycle and raises fifo_DataReady once a full FX3 burst is buffered.
// - Presents the head word on fx3_data in show-ahead (first-word-fall-through) form; pops one word per cycle while fx3_nWrite is low.
// - Flags overflow (samples lost) and underrun (FX3 write strobe while empty) as sticky status.

---
 rtl/fx3_sample_buffer_if.sv | 40 ++++
 rtl/fx3_sample_buffer.sv | 104 ++++++++++
 tb/tb_fx3_sample_buffer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fx3_sample_buffer_if.sv
// Bundle between the sample producer, the FX3 write-control FSM
// and the circular sample buffer feeding the GPIF data bus.
interface fx3_sample_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14
);
  logic [DATA_WIDTH-1:0] sample_data;
  logic                  sample_valid;
  logic                  fx3_nWrite;
  logic                  status_clear;
  logic [DATA_WIDTH-1:0] fx3_data;
  logic                  fifo_DataReady;
  logic [ADDR_WIDTH:0]   buffer_level;
  logic                  buffer_overflow;
  logic                  buffer_underrun;

  modport master (
    output sample_data,
    output sample_valid,
    output fx3_nWrite,
    output status_clear,
    input  fx3_data,
    input  fifo_DataReady,
    input  buffer_level,
    input  buffer_overflow,
    input  buffer_underrun
  );

  modport slave (
    input  sample_data,
    input  sample_valid,
    input  fx3_nWrite,
    input  status_clear,
    output fx3_data,
    output fifo_DataReady,
    output buffer_level,
    output buffer_overflow,
    output buffer_underrun
  );
endinterface

// File: rtl/fx3_sample_buffer.sv
// Circular show-ahead sample buffer in front of the FX3 GPIF write port.
// Raises fifo_DataReady once a full burst is held; sticky overflow/underrun.
module fx3_sample_buffer #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 14,
  parameter int BURST_WORDS = 8192
) (
  input  logic fx3_clock,
  input  logic fx3_reset,
  fx3_sample_buffer_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0] LVL_FULL =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LVL_BURST =
    (ADDR_WIDTH+1)'(BURST_WORDS);
  localparam logic [ADDR_WIDTH:0] LVL_ONE =
    (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE =
    ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wrPtr;
  logic [ADDR_WIDTH-1:0] rdPtr;
  logic [ADDR_WIDTH:0]   levelQ;
  logic [DATA_WIDTH-1:0] dataQ;
  logic                  dataReadyQ;
  logic                  overflowQ;
  logic                  underrunQ;

  logic                  full;
  logic                  empty;
  logic                  doWrite;
  logic                  doRead;
  logic                  overflowEv;
  logic                  underrunEv;
  logic                  headValid;
  logic [ADDR_WIDTH-1:0] rdPtrNext;
  logic [ADDR_WIDTH:0]   levelNext;

  // Edge decisions; full/empty come from the pre-edge level so a
  // write at full is dropped even if a read frees a slot this edge.
  // The head is refreshed only from words stored before this edge,
  // so a fresh word reaches fx3_data one edge after it is written
  // and the RAM never has to return a word written at the same edge.
  always_comb begin
    full       = (levelQ == LVL_FULL);
    empty      = (levelQ == '0);
    doWrite    = bus.sample_valid && !full;
    doRead     = !bus.fx3_nWrite && !empty;
    overflowEv = bus.sample_valid && full;
    underrunEv = !bus.fx3_nWrite && empty;
    rdPtrNext  = doRead ? rdPtr + PTR_ONE : rdPtr;
    headValid  = doRead ? (levelQ > LVL_ONE) : !empty;
    levelNext  = levelQ;
    unique case ({doWrite, doRead})
      2'b10:   levelNext = levelQ + LVL_ONE;
      2'b01:   levelNext = levelQ - LVL_ONE;
      default: levelNext = levelQ;
    endcase
  end

  // Sample RAM write port, contents are never reset.
  always_ff @(posedge fx3_clock) begin
    if (doWrite) begin
      mem[wrPtr] <= bus.sample_data;
    end
  end

  // Pointers, level, show-ahead head register and status flags.
  always_ff @(posedge fx3_clock) begin
    if (fx3_reset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      levelQ     <= '0;
      dataQ      <= '0;
      dataReadyQ <= 1'b0;
      overflowQ  <= 1'b0;
      underrunQ  <= 1'b0;
    end else begin
      if (doWrite) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      rdPtr      <= rdPtrNext;
      levelQ     <= levelNext;
      dataReadyQ <= (levelQ >= LVL_BURST);
      if (headValid) begin
        dataQ <= mem[rdPtrNext];
      end
      overflowQ <= (overflowQ && !bus.status_clear) || overflowEv;
      underrunQ <= (underrunQ && !bus.status_clear) || underrunEv;
    end
  end

  assign bus.fx3_data        = dataQ;
  assign bus.fifo_DataReady  = dataReadyQ;
  assign bus.buffer_level    = levelQ;
  assign bus.buffer_overflow = overflowQ;
  assign bus.buffer_underrun = underrunQ;

endmodule

// File: tb/tb_fx3_sample_buffer.sv
// Scoreboard bench for fx3_sample_buffer: queue-based reference model
// feeds expected per-edge outputs to an independent monitor.
module tb_fx3_sample_buffer;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int BW    = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fx3_sample_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  fx3_sample_buffer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BURST_WORDS(BW)
  ) dut (
    .fx3_clock(clk),
    .fx3_reset(rst),
    .bus      (bus)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW:0]   level;
    logic          ready;
    logic          ovf;
    logic          und;
  } exp_t;

  exp_t sb[$];

  int nChecks = 0;
  int nFails  = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] mShown = '0;
  logic          mReady = 1'b0;
  logic          mOvf   = 1'b0;
  logic          mUnd   = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model of one clock edge, stated in queue terms.
  task automatic modelEdge(bit v, logic [DW-1:0] d, bit nw,
                           bit clr, bit r);
    int  lvl;
    bit  wrote;
    bit  rd;
    exp_t e;
    lvl = mq.size();
    if (r) begin
      mq.delete();
      mShown = '0;
      mReady = 1'b0;
      mOvf   = 1'b0;
      mUnd   = 1'b0;
    end else begin
      wrote  = v && (lvl != DEPTH);
      rd     = !nw && (lvl != 0);
      mReady = (lvl >= BW);
      mOvf   = (mOvf && !clr) || (v && lvl == DEPTH);
      mUnd   = (mUnd && !clr) || (!nw && lvl == 0);
      if (rd) void'(mq.pop_front());
      if (wrote) mq.push_back(d);
      if (mq.size() > 0 && !(wrote && mq.size() == 1))
        mShown = mq[0];
    end
    e.data  = mShown;
    e.level = (AW+1)'(mq.size());
    e.ready = mReady;
    e.ovf   = mOvf;
    e.und   = mUnd;
    sb.push_back(e);
  endtask

  task automatic step(bit v, logic [DW-1:0] d, bit nw,
                      bit clr, bit r);
    @(negedge clk);
    rst              = r;
    bus.sample_valid = v;
    bus.sample_data  = d;
    bus.fx3_nWrite   = nw;
    bus.status_clear = clr;
    modelEdge(v, d, nw, clr, r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic rd1();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr1(logic [DW-1:0] d);
    step(1'b1, d, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: compare every presented output set against the model.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_data",  32'(bus.fx3_data),        32'(e.data));
        check("sb_level", 32'(bus.buffer_level),    32'(e.level));
        check("sb_ready", 32'(bus.fifo_DataReady),  32'(e.ready));
        check("sb_ovf",   32'(bus.buffer_overflow), 32'(e.ovf));
        check("sb_und",   32'(bus.buffer_underrun), 32'(e.und));
      end
    end
  end

  initial begin : stim
    logic [DW-1:0] held;
    int wait_cnt;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    bus.fx3_nWrite   = 1'b1;
    bus.status_clear = 1'b0;

    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("rst_level", 32'(bus.buffer_level),    0);
    check("rst_data",  32'(bus.fx3_data),        0);
    check("rst_ready", 32'(bus.fifo_DataReady),  0);
    check("rst_ovf",   32'(bus.buffer_overflow), 0);
    check("rst_und",   32'(bus.buffer_underrun), 0);

    for (int i = 1; i <= 4; i++) wr1(DW'(i));
    check("fill_level", 32'(bus.buffer_level), 4);
    check("fill_ready_early", 32'(bus.fifo_DataReady), 0);
    idle();
    check("fill_ready", 32'(bus.fifo_DataReady), 1);
    check("fill_data",  32'(bus.fx3_data), 32'h0001);

    for (int i = 0; i < 4; i++) begin
      rd1();
      check("burst_data", 32'(bus.fx3_data), (i < 3) ? i + 2 : 4);
    end
    check("burst_level", 32'(bus.buffer_level), 0);
    idle();
    check("burst_ready", 32'(bus.fifo_DataReady), 0);
    check("burst_und",   32'(bus.buffer_underrun), 0);

    for (int i = 1; i <= 10; i++) wr1(DW'(16'h0100 + i));
    check("ovf_level", 32'(bus.buffer_level), 8);
    check("ovf_flag",  32'(bus.buffer_overflow), 1);
    check("ovf_head",  32'(bus.fx3_data), 32'h0101);
    for (int i = 0; i < 8; i++) begin
      rd1();
      check("ovf_order", 32'(bus.fx3_data),
            (i < 7) ? 32'h0102 + i : 32'h0108);
    end
    check("ovf_drained", 32'(bus.buffer_level), 0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("ovf_clear", 32'(bus.buffer_overflow), 0);

    wr1(16'h0200);
    wr1(16'h0201);
    for (int i = 2; i < 20; i++) begin
      step(1'b1, DW'(16'h0200 + i), 1'b0, 1'b0, 1'b0);
      check("wrap_level", 32'(bus.buffer_level), 2);
      check("wrap_data",  32'(bus.fx3_data), 32'h0200 + i - 1);
    end
    rd1();
    rd1();
    check("wrap_tail",  32'(bus.fx3_data), 32'h0213);
    check("wrap_empty", 32'(bus.buffer_level), 0);
    check("wrap_ovf",   32'(bus.buffer_overflow), 0);
    check("wrap_und",   32'(bus.buffer_underrun), 0);

    held = bus.fx3_data;
    rd1();
    check("und_flag", 32'(bus.buffer_underrun), 1);
    check("und_data", 32'(bus.fx3_data), 32'(held));
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("und_clear", 32'(bus.buffer_underrun), 0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("und_wins", 32'(bus.buffer_underrun), 1);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);

    for (int i = 1; i <= 6; i++) wr1(DW'(16'h0300 + i));
    check("mid_level", 32'(bus.buffer_level), 6);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("mid_rst_level", 32'(bus.buffer_level),    0);
    check("mid_rst_ready", 32'(bus.fifo_DataReady),  0);
    check("mid_rst_data",  32'(bus.fx3_data),        0);
    check("mid_rst_ovf",   32'(bus.buffer_overflow), 0);
    check("mid_rst_und",   32'(bus.buffer_underrun), 0);
    for (int i = 1; i <= 3; i++) wr1(DW'(16'h0400 + i));
    idle();
    check("mid_restart", 32'(bus.fx3_data), 32'h0401);
    rd1();
    check("mid_next", 32'(bus.fx3_data), 32'h0402);
    rd1();
    rd1();

    for (int n = 0; n < 600; n++) begin
      int wb;
      int rb;
      wb = (n % 200 < 100) ? 75 : 35;
      rb = (n % 200 < 100) ? 35 : 75;
      step($urandom_range(0, 99) < wb,
           DW'($urandom),
           !($urandom_range(0, 99) < rb),
           $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 1);
    end
    idle();

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    check("sb_drain", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
